// File: rtl/fft2d_job_sequencer.sv
// rtl/fft2d_job_sequencer.sv - host job sequencer around the 2D FFT engine
// Loads a frame, runs the engine with a watchdog, then unloads the frame.
module fft2d_job_sequencer #(
  parameter int ROW_BITS       = 5,
  parameter int COL_BITS       = 5,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int START_WAIT     = 15
) (
  input  logic                extc_base_clock,
  input  logic                extc_asyn_reset,
  input  logic                host_start,
  input  logic                host_inverse,
  output logic                host_busy,
  output logic                host_done,
  output logic                host_error,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ram_wr_en,
  output logic                ram_rd_en,
  output logic [ROW_BITS-1:0] ram_row,
  output logic [COL_BITS-1:0] ram_col,
  output logic                core_hold,
  output logic                core_inverse,
  input  logic                core_busy
);

  localparam int AW = ROW_BITS + COL_BITS;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_TIMEOUT = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_START   = WW'(START_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_UNLOAD
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [WW-1:0]   watchdog;
  logic            busy_seen;
  logic            rd_last;

  // Row and column counters form one row-major address that wraps naturally.
  assign {ram_row, ram_col} = addr;
  assign in_ready  = (state == S_LOAD);
  assign ram_wr_en = in_valid & in_ready;
  assign ram_rd_en = (state == S_UNLOAD) & ~rd_last & (~out_valid | out_ready);

  always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
    if (extc_asyn_reset) begin
      state        <= S_IDLE;
      addr         <= '0;
      watchdog     <= '0;
      busy_seen    <= 1'b0;
      rd_last      <= 1'b0;
      host_busy    <= 1'b0;
      host_done    <= 1'b0;
      host_error   <= 1'b0;
      out_valid    <= 1'b0;
      core_hold    <= 1'b1;
      core_inverse <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_start) begin
            core_inverse <= host_inverse;
            host_error   <= 1'b0;
            addr         <= '0;
            host_busy    <= 1'b1;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ram_wr_en) begin
            addr <= addr + 1'b1;
            if (&addr) begin
              core_hold <= 1'b0;
              watchdog  <= '0;
              busy_seen <= 1'b0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          watchdog <= watchdog + 1'b1;
          if (watchdog == WD_TIMEOUT) begin
            host_error <= 1'b1;
            host_done  <= 1'b1;
            core_hold  <= 1'b1;
            state      <= S_DONE;
          end else if (!busy_seen) begin
            if (core_busy) begin
              busy_seen <= 1'b1;
            end else if (watchdog >= WD_START) begin
              host_error <= 1'b1;
              host_done  <= 1'b1;
              core_hold  <= 1'b1;
              state      <= S_DONE;
            end
          end else if (!core_busy) begin
            // First low sample after busy was seen is the engine's falling edge.
            core_hold <= 1'b1;
            addr      <= '0;
            rd_last   <= 1'b0;
            state     <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          out_valid <= ram_rd_en | (out_valid & ~out_ready);
          if (ram_rd_en) begin
            addr <= addr + 1'b1;
            if (&addr) begin
              rd_last <= 1'b1;
            end
          end
          if (rd_last && out_valid && out_ready) begin
            rd_last   <= 1'b0;
            host_done <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          host_done <= 1'b0;
          host_busy <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft2d_job_sequencer.sv
// tb/tb_fft2d_job_sequencer.sv - randomized self-checking bench for fft2d_job_sequencer
module tb_fft2d_job_sequencer;

  localparam int RB = 2;
  localparam int CB = 2;
  localparam int NW = 1 << (RB + CB);
  localparam int TMO = 100;
  localparam int SW = 15;

  logic          extc_base_clock = 1'b0;
  logic          extc_asyn_reset = 1'b1;
  logic          host_start = 1'b0;
  logic          host_inverse = 1'b0;
  logic          host_busy, host_done, host_error;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          ram_wr_en, ram_rd_en;
  logic [RB-1:0] ram_row;
  logic [CB-1:0] ram_col;
  logic          core_hold, core_inverse;
  logic          core_busy = 1'b0;

  fft2d_job_sequencer #(
    .ROW_BITS(RB), .COL_BITS(CB), .TIMEOUT_CYCLES(TMO), .START_WAIT(SW)
  ) dut (
    .extc_base_clock(extc_base_clock), .extc_asyn_reset(extc_asyn_reset),
    .host_start(host_start), .host_inverse(host_inverse),
    .host_busy(host_busy), .host_done(host_done), .host_error(host_error),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_row(ram_row), .ram_col(ram_col),
    .core_hold(core_hold), .core_inverse(core_inverse), .core_busy(core_busy)
  );

  always #5 extc_base_clock = ~extc_base_clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model and stream drivers: mode 0 normal, 1 busy stuck high, 2 busy never rises.
  int mode = 0;
  bit bp_en = 1'b0;
  bit exp_inv = 1'b0;
  int rel = 0;

  initial begin
    forever begin
      @(posedge extc_base_clock);
      #1;
      if (core_hold) rel = 0;
      else rel++;
      case (mode)
        0:       core_busy = (rel >= 3) && (rel < 43);
        1:       core_busy = (rel >= 3);
        default: core_busy = 1'b0;
      endcase
      in_valid  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Observation log, sampled on the falling edge.
  int cyc = 0;
  int wr_q[$];
  int rd_q[$];
  int rd_cyc_q[$];
  int done_cnt = 0, done_cyc = 0, fall_cyc = 0, hold0_cnt = 0;
  int inv_bad = 0, drop_bad = 0, both_bad = 0, busy_at_done = 0;
  bit prev_ov = 1'b0, prev_or = 1'b0, prev_busy = 1'b0;

  always @(negedge extc_base_clock) begin
    cyc++;
    if (extc_asyn_reset) begin
      prev_ov = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (ram_wr_en) wr_q.push_back(int'({ram_row, ram_col}));
      if (ram_rd_en) begin
        rd_q.push_back(int'({ram_row, ram_col}));
        rd_cyc_q.push_back(cyc);
      end
      if (ram_wr_en && ram_rd_en) both_bad++;
      if (host_done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(host_busy);
      end
      if (prev_busy && !core_busy) fall_cyc = cyc;
      if (!core_hold) begin
        hold0_cnt++;
        if (core_inverse != exp_inv) inv_bad++;
      end
      if (prev_ov && !prev_or && !out_valid) drop_bad++;
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_busy = core_busy;
    end
  end

  function automatic int reset_vec();
    return int'({host_busy, host_done, host_error, in_ready, out_valid, ram_wr_en,
                 ram_rd_en, ram_row, ram_col, core_hold, core_inverse});
  endfunction

  task automatic run_job(input bit inv, input int m, input bit bp, input int abort_at,
                         input string tag);
    int wb, rb, db, hb, ib, drb, bb, k, nw, nr, exp_rd;
    bit got_end;
    k = 0;
    while (host_busy && k < 300) begin
      @(negedge extc_base_clock);
      k++;
    end
    @(posedge extc_base_clock);
    #1;
    wb = wr_q.size(); rb = rd_q.size(); db = done_cnt; hb = hold0_cnt;
    ib = inv_bad; drb = drop_bad; bb = both_bad;
    mode = m; bp_en = bp; exp_inv = inv;
    host_start = 1'b1;
    host_inverse = inv;
    @(posedge extc_base_clock);
    #1;
    host_start = 1'b0;
    host_inverse = 1'($urandom_range(0, 1));
    chk({tag, "_busy_on_start"}, int'(host_busy), 1);
    chk({tag, "_error_cleared"}, int'(host_error), 0);

    got_end = 1'b0;
    k = 0;
    while (!got_end && k < 3000) begin
      @(negedge extc_base_clock);
      #1;
      k++;
      if (done_cnt != db) begin
        got_end = 1'b1;
      end else if (abort_at >= 0 && rd_q.size() - rb >= abort_at) begin
        extc_asyn_reset = 1'b1;
        #1;
        chk({tag, "_reset_outputs"}, reset_vec(), 'h002);
        @(posedge extc_base_clock);
        @(negedge extc_base_clock);
        extc_asyn_reset = 1'b0;
        got_end = 1'b1;
      end
    end
    if (!got_end) chk({tag, "_job_end_timeout"}, 0, 1);

    nw = wr_q.size() - wb;
    chk({tag, "_write_count"}, nw, NW);
    for (int i = 0; i < nw && i < NW; i++) chk({tag, "_write_addr"}, wr_q[wb + i], i);
    if (abort_at >= 0) return;

    exp_rd = (m == 0) ? NW : 0;
    nr = rd_q.size() - rb;
    chk({tag, "_done_pulses"}, done_cnt - db, 1);
    chk({tag, "_read_count"}, nr, exp_rd);
    for (int i = 0; i < nr && i < NW; i++) chk({tag, "_read_addr"}, rd_q[rb + i], i);
    chk({tag, "_error"}, int'(host_error), (m != 0) ? 1 : 0);
    chk({tag, "_inverse_during_run"}, inv_bad - ib, 0);
    chk({tag, "_valid_drop"}, drop_bad - drb, 0);
    chk({tag, "_wr_rd_overlap"}, both_bad - bb, 0);
    chk({tag, "_busy_at_done"}, busy_at_done, 1);
    if (m == 1) chk({tag, "_run_cycles"}, hold0_cnt - hb, TMO + 1);
    if (m == 2) chk({tag, "_run_cycles"}, hold0_cnt - hb, SW + 1);
    if (m == 0 && !bp && nr == NW) begin
      chk({tag, "_unload_latency"}, rd_cyc_q[rb] - fall_cyc, 1);
      chk({tag, "_unload_rate"}, rd_cyc_q[rb + NW - 1] - rd_cyc_q[rb], NW - 1);
      chk({tag, "_done_latency"}, done_cyc - rd_cyc_q[rb], NW + 1);
    end
    @(negedge extc_base_clock);
    #1;
    chk({tag, "_busy_after_done"}, int'(host_busy), 0);
    chk({tag, "_done_single"}, int'(host_done), 0);
    chk({tag, "_hold_after_job"}, int'(core_hold), 1);
  endtask

  initial begin
    repeat (3) @(negedge extc_base_clock);
    chk("reset_state", reset_vec(), 'h002);
    extc_asyn_reset = 1'b0;
    @(negedge extc_base_clock);
    chk("idle_after_reset", reset_vec(), 'h002);

    run_job(1'b0, 0, 1'b0, -1, "fwd");
    for (int j = 0; j < 3; j++) run_job(1'($urandom_range(0, 1)), 0, 1'b1, -1, "bp");
    run_job(1'b0, 1, 1'b0, -1, "timeout");
    run_job(1'b1, 0, 1'b1, -1, "after_timeout");
    run_job(1'b0, 2, 1'b0, -1, "nostart");
    run_job(1'b0, 0, 1'b0, 7, "abort");
    @(negedge extc_base_clock);
    chk("post_abort_outputs", reset_vec(), 'h002);
    run_job(1'b1, 0, 1'b0, -1, "ifft");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft2d_job_sequencer.md
Name: fft2d_job_sequencer

Overview:
- Host-facing job sequencer wrapped around the 2D FFT engine.
- Loads one N×N frame into the row RAMs through a valid/ready stream, then starts the 2D FFT engine (row FFT, transpose, row FFT) in forward or inverse mode.
- Waits for the engine to finish, then unloads the frame through an output valid/ready stream.
- Owns the RAM row/column addressing during the load and unload phases, and keeps the engine in reset whenever no job is running.

Parameters:
- ROW_BITS, 5, log2 of RAM rows (32 rows).
- COL_BITS, 5, log2 of words per row (32 words).
- TIMEOUT_CYCLES, 65535, maximum RUN duration before the job is aborted with an error.
- START_WAIT, 15, maximum cycles allowed for core_busy to rise after the core is released.

Ports:
- extc_base_clock  in  1  system clock; all logic on its rising edge.
- extc_asyn_reset  in  1  asynchronous reset, active-high.
- host_start  in  1  job request, level-sampled; accepted only in IDLE.
- host_inverse  in  1  1 = IFFT job; sampled on the accepted start.
- host_busy  out  1  high from start acceptance through the end of DONE.
- host_done  out  1  one-cycle pulse at job end.
- host_error  out  1  sticky timeout flag; cleared on the next accepted start.
- in_valid  in  1  load stream word valid.
- in_ready  out  1  load stream ready.
- out_valid  out  1  unload stream word valid.
- out_ready  in  1  unload stream ready.
- ram_wr_en  out  1  RAM write strobe.
- ram_rd_en  out  1  RAM read strobe; read data arrives 1 cycle later.
- ram_row  out  ROW_BITS  RAM row address.
- ram_col  out  COL_BITS  RAM column address.
- core_hold  out  1  drives the 2D engine reset; high = engine held idle.
- core_inverse  out  1  mode bit to the engine, stable for the whole RUN.
- core_busy  in  1  engine busy flag.

Behaviour:
- Reset values: state IDLE; row/col counters 0; host_busy 0; host_done 0; host_error 0; in_ready 0; out_valid 0; ram_wr_en 0; ram_rd_en 0; core_hold 1; core_inverse 0.
- States: IDLE, LOAD, RUN, DONE, UNLOAD. Encoding is free.
- IDLE:
  - On host_start = 1: latch host_inverse into core_inverse, clear host_error and the counters, go to LOAD, set host_busy = 1.
- LOAD:
  - in_ready = 1 (combinational in this state).
  - ram_wr_en = in_valid & in_ready.
  - ram_row/ram_col = counters.
  - Each accepted word: col + 1; when col wraps from all-ones to 0, row + 1.
  - On acceptance of word (row = all-ones, col = all-ones): counters go to 0, go to RUN, in_ready drops next cycle.
  - No timeout in LOAD; the host may stall indefinitely.
- RUN:
  - core_hold = 0 from the first RUN cycle.
  - Watchdog counter starts at 0 on entry and increments every cycle.
  - Sub-phase A: wait for core_busy = 1. If START_WAIT cycles pass without it, set host_error and go to DONE.
  - Sub-phase B: after core_busy has risen, its falling edge (1→0) goes to UNLOAD.
  - Watchdog = TIMEOUT_CYCLES in either sub-phase: set host_error, go to DONE, skip UNLOAD.
  - core_hold returns to 1 on the cycle the state leaves RUN.
- UNLOAD:
  - Issue a read (ram_rd_en = 1, addresses = counters) when out_valid = 0 or out_ready = 1. The counters advance on each issued read.
  - out_valid registers ram_rd_en (1-cycle RAM latency).
  - out_valid stays high until out_ready = 1, so there is never more than one word in flight.
  - After the read of the last address is issued, stop issuing. Go to DONE once that final word is consumed (out_valid & out_ready).
- DONE:
  - host_done = 1 for exactly one cycle, then host_busy = 0 and state IDLE.
  - host_start held high during DONE is not accepted until IDLE is reached.
- Counters: unsigned, wrap naturally at ROW_BITS/COL_BITS. Total words per phase = 2^(ROW_BITS+COL_BITS).
- Simultaneous events: in DONE, host_start is ignored. In UNLOAD, out_ready on the same cycle as the issue condition allows a back-to-back read, giving 1 word/cycle throughput.
- Reset mid-job: immediate return to IDLE with all reset values, including core_hold = 1 (aborts the engine). Partial RAM contents are undefined.
- ram_wr_en and ram_rd_en are never high in the same cycle.

Test Plan:
- Forward job, ROW_BITS = COL_BITS = 2: start with host_inverse = 0, stream 16 words with in_valid held high.
  - ram_wr_en high 16 cycles; addresses (0,0)…(3,3) in row-major order.
  - RUN entered; core_inverse = 0, core_hold = 0.
- Core model raises busy 3 cycles after release and drops it 40 cycles later.
  - UNLOAD starts 1 cycle after the fall.
  - With out_ready = 1, 16 words arrive at 1/cycle; host_done pulses once; host_busy falls the following cycle.
- Backpressure: toggle in_valid and out_ready randomly.
  - No address is skipped or duplicated; out_valid never drops without out_ready; exactly 16 writes and 16 reads.
- Timeout: TIMEOUT_CYCLES = 100, core_busy stuck at 1.
  - host_error = 1 after 100 RUN cycles; no UNLOAD; host_done pulses.
  - The next start clears host_error.
- No-start fault: core_busy never rises.
  - host_error set after START_WAIT cycles; core_hold back to 1.
- Reset mid-UNLOAD (word 7), then an IFFT job.
  - After reset all outputs are at reset values.
  - The new job latches core_inverse = 1 and restarts addressing at (0,0).
